prog_data_mem: RTL and testbench

Parametrised instruction/data memory for the RISC core, replacing the fixed 1K×16 / 256×8 memory pair. It adds a streaming boot loader that fills instruction and data memory after reset, so images no longer come from files. It also adds registered, enable-qualified data reads with a valid flag, and optional write-to-read bypass. It sits between the core's fetch/load-store stages and the external program source.

---
 rtl/prog_data_mem_pkg.sv | 19 +
 rtl/boot_loader_fsm.sv | 77 +++++++
 rtl/prog_data_mem.sv | 99 +++++++++
 tb/tb_prog_data_mem.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_data_mem_pkg.sv
// Shared types and default widths for the program/data memory block.
package prog_data_mem_pkg;

  localparam int IADDR_W_DEF = 10;
  localparam int IDATA_W_DEF = 16;
  localparam int DADDR_W_DEF = 8;
  localparam int DDATA_W_DEF = 8;

  typedef enum logic [1:0] {
    LOAD_I = 2'd0,
    LOAD_D = 2'd1,
    RUN    = 2'd2
  } boot_state_e;

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_loader_fsm.sv
// Boot sequencer: streams loader words into instruction then data memory,
// then parks in RUN until reset. Owns the shared fill pointer.
module boot_loader_fsm
  import prog_data_mem_pkg::*;
#(
  parameter int IADDR_W = IADDR_W_DEF,
  parameter int DADDR_W = DADDR_W_DEF,
  parameter int PTR_W   = max_w(IADDR_W, DADDR_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_valid,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             mem_ready,
  output logic             ld_overflow,
  output logic             imem_we,
  output logic             dmem_we,
  output logic [PTR_W-1:0] ld_ptr
);

  localparam logic [PTR_W-1:0] ITOP = PTR_W'((1 << IADDR_W) - 1);
  localparam logic [PTR_W-1:0] DTOP = PTR_W'((1 << DADDR_W) - 1);

  boot_state_e      state_q, state_d;
  logic [PTR_W-1:0] ptr_d;
  logic             ovf_d;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_I;
      ld_ptr      <= '0;
      ld_overflow <= 1'b0;
    end else begin
      state_q     <= state_d;
      ld_ptr      <= ptr_d;
      ld_overflow <= ovf_d;
    end
  end

  assign accept = ld_valid && (state_q != RUN);

  // A section ends on ld_last or when it fills its memory; the latter is an overflow.
  always_comb begin
    state_d = state_q;
    ptr_d   = ld_ptr;
    ovf_d   = ld_overflow;
    case (state_q)
      LOAD_I: if (accept) begin
        ptr_d = ld_ptr + 1'b1;
        if (ld_last || ld_ptr == ITOP) begin
          state_d = LOAD_D;
          ptr_d   = '0;
          if (!ld_last) ovf_d = 1'b1;
        end
      end
      LOAD_D: if (accept) begin
        ptr_d = ld_ptr + 1'b1;
        if (ld_last || ld_ptr == DTOP) begin
          state_d = RUN;
          ptr_d   = '0;
          if (!ld_last) ovf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_ready  = (state_q != RUN);
    mem_ready = (state_q == RUN);
    imem_we   = ld_valid && (state_q == LOAD_I);
    dmem_we   = ld_valid && (state_q == LOAD_D);
  end

endmodule

// File: rtl/prog_data_mem.sv
// Instruction/data memory with streaming boot loader and registered reads.
// Optional DMEM_BYPASS_EN: same-cycle read/write to one address returns the new data.
module prog_data_mem
  import prog_data_mem_pkg::*;
#(
  parameter int IADDR_W = IADDR_W_DEF,
  parameter int IDATA_W = IDATA_W_DEF,
  parameter int DADDR_W = DADDR_W_DEF,
  parameter int DDATA_W = DDATA_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [IADDR_W-1:0] prog_ctr,
  output logic [IDATA_W-1:0] instr_mem_out,
  output logic               instr_valid,
  input  logic               data_rd_en,
  input  logic [DADDR_W-1:0] data_rd_addr,
  output logic [DDATA_W-1:0] datamem_rd_data,
  output logic               data_rd_valid,
  input  logic               store_to_mem,
  input  logic [DADDR_W-1:0] data_wr_addr,
  input  logic [DDATA_W-1:0] datamem_wr_data,
  input  logic               ld_valid,
  input  logic [IDATA_W-1:0] ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               mem_ready,
  output logic               ld_overflow
);

  localparam int PTR_W = max_w(IADDR_W, DADDR_W);

  logic             imem_we, dmem_we, store_we;
  logic [PTR_W-1:0] ld_ptr;
  logic [DDATA_W-1:0] rd_word;

  logic [IDATA_W-1:0] imem [0:(1<<IADDR_W)-1];
  logic [DDATA_W-1:0] dmem [0:(1<<DADDR_W)-1];

  boot_loader_fsm #(
    .IADDR_W (IADDR_W),
    .DADDR_W (DADDR_W),
    .PTR_W   (PTR_W)
  ) u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_valid    (ld_valid),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .mem_ready   (mem_ready),
    .ld_overflow (ld_overflow),
    .imem_we     (imem_we),
    .dmem_we     (dmem_we),
    .ld_ptr      (ld_ptr)
  );

  assign store_we = store_to_mem && mem_ready;

  // Arrays carry no reset so an image survives a core reset.
  always_ff @(posedge clk) begin
    if (imem_we) imem[ld_ptr[IADDR_W-1:0]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (dmem_we)       dmem[ld_ptr[DADDR_W-1:0]] <= ld_data[DDATA_W-1:0];
    else if (store_we) dmem[data_wr_addr]        <= datamem_wr_data;
  end

`ifdef DMEM_BYPASS_EN
  assign rd_word = (store_we && data_wr_addr == data_rd_addr) ? datamem_wr_data
                                                              : dmem[data_rd_addr];
`else
  assign rd_word = dmem[data_rd_addr];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_mem_out <= '0;
      instr_valid   <= 1'b0;
    end else if (mem_ready) begin
      instr_mem_out <= imem[prog_ctr];
      instr_valid   <= 1'b1;
    end else begin
      instr_mem_out <= '0;
      instr_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datamem_rd_data <= '0;
      data_rd_valid   <= 1'b0;
    end else begin
      data_rd_valid <= data_rd_en && mem_ready;
      if (data_rd_en && mem_ready) datamem_rd_data <= rd_word;
    end
  end

endmodule

// File: tb/tb_prog_data_mem.sv
// Self-checking bench for prog_data_mem: boot sequences, vector table, random model run.
module tb_prog_data_mem;

`ifdef DMEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  prog_ctr;
  logic [15:0] instr_mem_out;
  logic        instr_valid;
  logic        data_rd_en;
  logic [7:0]  data_rd_addr;
  logic [7:0]  datamem_rd_data;
  logic        data_rd_valid;
  logic        store_to_mem;
  logic [7:0]  data_wr_addr;
  logic [7:0]  datamem_wr_data;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic        mem_ready;
  logic        ld_overflow;

  prog_data_mem dut (
    .clk(clk), .rst_n(rst_n), .prog_ctr(prog_ctr),
    .instr_mem_out(instr_mem_out), .instr_valid(instr_valid),
    .data_rd_en(data_rd_en), .data_rd_addr(data_rd_addr),
    .datamem_rd_data(datamem_rd_data), .data_rd_valid(data_rd_valid),
    .store_to_mem(store_to_mem), .data_wr_addr(data_wr_addr),
    .datamem_wr_data(datamem_wr_data), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .mem_ready(mem_ready),
    .ld_overflow(ld_overflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_imem [0:1023];
  logic [7:0]  m_dmem [0:255];

  typedef struct {
    logic       rd_en;
    logic [7:0] ra;
    logic       we;
    logic [7:0] wa;
    logic [7:0] wd;
    logic       exp_v;
    logic [7:0] exp_d;
  } vec_t;
  vec_t tbl [10];

  function automatic logic [15:0] ipat(input int i);
    return 16'((i * 7) + 16'h0100);
  endfunction
  function automatic logic [7:0] dpat(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    prog_ctr = '0; data_rd_en = 0; data_rd_addr = '0; store_to_mem = 0;
    data_wr_addr = '0; datamem_wr_data = '0; ld_valid = 0; ld_data = '0; ld_last = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    ld_valid = 1; ld_data = d; ld_last = last;
    step();
    ld_valid = 0; ld_last = 0;
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    #2;
    // Reset values
    do_reset();
    chk("rst_instr_out", instr_mem_out, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_rd_data", datamem_rd_data, 0);
    chk("rst_rd_valid", data_rd_valid, 0);
    chk("rst_overflow", ld_overflow, 0);
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_mem_ready", mem_ready, 0);

    // Overflow boot: fill every instruction and data word, never ld_last
    for (int i = 0; i < 1024; i++) begin
      send(ipat(i), 1'b0);
      m_imem[i] = ipat(i);
    end
    chk("ovf_i_flag", ld_overflow, 1);
    chk("ovf_i_ld_ready", ld_ready, 1);
    chk("ovf_i_mem_ready", mem_ready, 0);
    chk("ovf_i_instr_valid", instr_valid, 0);
    for (int i = 0; i < 256; i++) begin
      send({8'hC3, dpat(i)}, 1'b0);
      m_dmem[i] = dpat(i);
    end
    chk("ovf_d_mem_ready", mem_ready, 1);
    chk("ovf_d_ld_ready", ld_ready, 0);
    step(); step();
    chk("ovf_sticky_run", ld_overflow, 1);

    // Normal boot after reset; stores during load must be dropped
    do_reset();
    chk("rst2_overflow", ld_overflow, 0);
    chk("rst2_mem_ready", mem_ready, 0);
    store_to_mem = 1; data_wr_addr = 8'h10; datamem_wr_data = 8'hEE;
    send(16'h1111, 0);
    send(16'h2222, 0);
    send(16'h3333, 1);
    chk("boot_in_load_d", mem_ready, 0);
    send(16'h00AA, 0);
    chk("boot_after4", mem_ready, 0);
    store_to_mem = 0;
    send(16'h00BB, 1);
    chk("boot_after5", mem_ready, 1);
    chk("boot_no_fetch_yet", instr_valid, 0);
    m_imem[0] = 16'h1111; m_imem[1] = 16'h2222; m_imem[2] = 16'h3333;
    m_dmem[0] = 8'hAA; m_dmem[1] = 8'hBB;
    prog_ctr = 10'd1;
    step();
    chk("fetch1_data", instr_mem_out, 16'h2222);
    chk("fetch1_valid", instr_valid, 1);

    // Vector table: read path, hold, same-address collision, dropped-store check
    tbl[0] = '{1, 8'h01, 0, 8'h00, 8'h00, 1, 8'hBB};
    tbl[1] = '{0, 8'h01, 0, 8'h00, 8'h00, 0, 8'hBB};
    tbl[2] = '{1, 8'h01, 1, 8'h01, 8'h5C, 1, BYP ? 8'h5C : 8'hBB};
    tbl[3] = '{1, 8'h01, 0, 8'h00, 8'h00, 1, 8'h5C};
    tbl[4] = '{1, 8'h10, 0, 8'h00, 8'h00, 1, dpat(8'h10)};
    tbl[5] = '{0, 8'h00, 1, 8'h20, 8'h33, 0, dpat(8'h10)};
    tbl[6] = '{1, 8'h20, 0, 8'h00, 8'h00, 1, 8'h33};
    tbl[7] = '{1, 8'h00, 1, 8'h05, 8'h77, 1, 8'hAA};
    tbl[8] = '{1, 8'h05, 0, 8'h00, 8'h00, 1, 8'h77};
    tbl[9] = '{1, 8'hFF, 0, 8'h00, 8'h00, 1, dpat(8'hFF)};
    for (int i = 0; i < 10; i++) begin
      data_rd_en = tbl[i].rd_en; data_rd_addr = tbl[i].ra;
      store_to_mem = tbl[i].we; data_wr_addr = tbl[i].wa; datamem_wr_data = tbl[i].wd;
      step();
      if (tbl[i].we) m_dmem[tbl[i].wa] = tbl[i].wd;
      chk($sformatf("tbl%0d_valid", i), data_rd_valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_data", i), datamem_rd_data, tbl[i].exp_d);
    end

    // Random traffic against the memory model
    begin
      logic [7:0] exp_d;
      logic       exp_v;
      logic [15:0] exp_i;
      exp_d = datamem_rd_data;
      for (int c = 0; c < 400; c++) begin
        prog_ctr     = 10'($urandom_range(0, 1023));
        data_rd_en   = 1'($urandom_range(0, 1));
        store_to_mem = 1'($urandom_range(0, 1));
        data_rd_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        data_wr_addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
        datamem_wr_data = 8'($urandom);
        ld_valid = 1'($urandom_range(0, 1));
        ld_data  = 16'($urandom);
        exp_i = m_imem[prog_ctr];
        exp_v = data_rd_en;
        if (data_rd_en)
          exp_d = (BYP && store_to_mem && data_wr_addr == data_rd_addr) ? datamem_wr_data
                                                                        : m_dmem[data_rd_addr];
        if (store_to_mem) m_dmem[data_wr_addr] = datamem_wr_data;
        step();
        chk("rnd_instr", instr_mem_out, exp_i);
        chk("rnd_rd_valid", data_rd_valid, exp_v);
        chk("rnd_rd_data", datamem_rd_data, exp_d);
      end
      idle_inputs();
    end
    chk("rnd_still_run", mem_ready, 1);

    // Reset in the middle of an instruction load, then a full reload
    do_reset();
    send(16'hA001, 0);
    send(16'hA002, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_instr_valid", instr_valid, 0);
    chk("midrst_mem_ready", mem_ready, 0);
    chk("midrst_ld_ready", ld_ready, 1);
    step();
    rst_n = 1'b1;
    send(16'hB001, 0);
    send(16'hB002, 0);
    send(16'hB003, 1);
    send(16'h0011, 0);
    send(16'h0022, 1);
    chk("reload_mem_ready", mem_ready, 1);
    prog_ctr = 10'd0;
    step();
    chk("reload_addr0", instr_mem_out, 16'hB001);
    prog_ctr = 10'd1;
    step();
    chk("reload_addr1", instr_mem_out, 16'hB002);
    prog_ctr = 10'd2;
    data_rd_en = 1; data_rd_addr = 8'h01;
    step();
    chk("reload_addr2", instr_mem_out, 16'hB003);
    chk("reload_dmem1", datamem_rd_data, 8'h22);
    data_rd_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
